key_search_sequencer: RTL and testbench

KEY_SEARCH_SEQUENCER -- requirements
Module: key_search_sequencer

---
 rtl/key_search_sequencer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_key_search_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_search_sequencer.sv
// key_search_sequencer
//   Sequences a bank of N_CORES RC4 decrypt cores through their phases
//   (init, shuffle, read, decrypt) in lockstep. Each core gets a
//   consecutive key. The sequencer either tries one key taken from the
//   switches or sweeps KEY_MIN..KEY_MAX in batches of N_CORES keys. It stops
//   on the first plaintext-valid core, on exhaustion, or on a phase watchdog
//   timeout.
//
// Ports
//   CLOCK_50                   sole clock, rising edge
//   reset                      asynchronous active-high reset
//   key_from_switches_changed  synchronous restart request (forces CLEAR)
//   search_mode                0 = single switch key, 1 = exhaustive search
//   switch_key                 key used in single mode
//   ROM_mem_read               encrypted message ROM ready; starts a run
//   init_done .. decrypt_done  per-core phase completion (pulse or level)
//   decrypt_valid              per-core plaintext valid, qualified by decrypt_done
//   reset_all                  core reset, high only in CLEAR
//   start_init .. start_decrypt  high throughout the matching phase state
//   core_key                   key for core c in [c*KEY_WIDTH +: KEY_WIDTH]
//   core_en                    core holds an in-range key this batch
//   current_state              state code
//   found/exhausted/timeout_err/done  terminal status
//   found_key, found_core      winning key and core index
module key_search_sequencer #(
  parameter int                  N_CORES        = 4,
  parameter int                  KEY_WIDTH      = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_MIN       = '0,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX       = 24'h3FFFFF,
  parameter int                  TIMEOUT_CYCLES = 65535,
  localparam int                 CORE_W         = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic                           key_from_switches_changed,
  input  logic                           search_mode,
  input  logic [KEY_WIDTH-1:0]           switch_key,
  input  logic                           ROM_mem_read,
  input  logic [N_CORES-1:0]             init_done,
  input  logic [N_CORES-1:0]             shuffle_done,
  input  logic [N_CORES-1:0]             read_done,
  input  logic [N_CORES-1:0]             decrypt_done,
  input  logic [N_CORES-1:0]             decrypt_valid,
  output logic                           reset_all,
  output logic                           start_init,
  output logic                           start_shuffle,
  output logic                           start_read,
  output logic                           start_decrypt,
  output logic [N_CORES*KEY_WIDTH-1:0]   core_key,
  output logic [N_CORES-1:0]             core_en,
  output logic [3:0]                     current_state,
  output logic                           found,
  output logic                           exhausted,
  output logic                           timeout_err,
  output logic                           done,
  output logic [KEY_WIDTH-1:0]           found_key,
  output logic [CORE_W-1:0]              found_core
);

  localparam int KW1 = KEY_WIDTH + 1;
  localparam int KW2 = KEY_WIDTH + 2;
  localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CLEAR    = 4'd1,
    S_LOAD     = 4'd2,
    S_INIT     = 4'd3,
    S_SHUFFLE  = 4'd4,
    S_READ_S   = 4'd5,
    S_DECRYPT  = 4'd6,
    S_CHECK    = 4'd7,
    S_NEXT_KEY = 4'd8,
    S_FOUND    = 4'd9,
    S_FAIL     = 4'd10,
    S_TIMEOUT  = 4'd11
  } state_t;

  state_t                 state_reg, state_next;
  logic [KEY_WIDTH-1:0]   base_reg;
  logic [N_CORES-1:0]     core_en_reg;
  logic [N_CORES-1:0]     seen_reg;
  logic [N_CORES-1:0]     valid_seen_reg;
  logic                   mode_reg;
  logic                   entry_reg;
  logic [31:0]            watchdog_reg;
  logic [KEY_WIDTH-1:0]   found_key_reg;
  logic [CORE_W-1:0]      found_core_reg;

  logic                   state_change;
  logic                   in_phase;
  logic [N_CORES-1:0]     phase_done_in;
  logic                   phase_complete;
  logic                   wd_expired;
  logic [KW1-1:0]         load_base_ext;
  logic [KW1-1:0]         next_base_ext;
  logic [N_CORES-1:0]     load_en;
  logic [N_CORES-1:0]     next_en;
  logic                   last_batch;
  logic [CORE_W-1:0]      win_idx;
  logic [KEY_WIDTH-1:0]   win_key;

  // Enable a core when its untruncated key is still within KEY_MAX.
  function automatic logic [N_CORES-1:0] range_enables(input logic [KW1-1:0] b);
    logic [KW2-1:0] k;
    range_enables = '0;
    for (int c = 0; c < N_CORES; c++) begin
      k = {1'b0, b} + KW2'(c);
      range_enables[c] = (k <= {2'b00, KEY_MAX});
    end
  endfunction

  assign state_change   = (state_next != state_reg);
  assign in_phase       = (state_reg == S_INIT) || (state_reg == S_SHUFFLE) ||
                          (state_reg == S_READ_S) || (state_reg == S_DECRYPT);
  assign phase_complete = &(seen_reg | ~core_en_reg);
  assign wd_expired     = (TIMEOUT_CYCLES != 0) && (watchdog_reg == WD_LIMIT);

  assign load_base_ext  = search_mode ? {1'b0, KEY_MIN} : {1'b0, switch_key};
  assign next_base_ext  = {1'b0, base_reg} + KW1'(N_CORES);
  assign load_en        = search_mode ? range_enables(load_base_ext) : N_CORES'(1);
  assign next_en        = range_enables(next_base_ext);
  // Compared one bit wider so a sweep ending near 2^KEY_WIDTH cannot wrap.
  assign last_batch     = (next_base_ext > {1'b0, KEY_MAX});

  always_comb begin
    phase_done_in = '0;
    case (state_reg)
      S_INIT:    phase_done_in = init_done;
      S_SHUFFLE: phase_done_in = shuffle_done;
      S_READ_S:  phase_done_in = read_done;
      S_DECRYPT: phase_done_in = decrypt_done;
      default:   phase_done_in = '0;
    endcase
  end

  // Lowest valid core index wins.
  always_comb begin
    win_idx = '0;
    for (int c = N_CORES - 1; c >= 0; c--) begin
      if (valid_seen_reg[c]) win_idx = CORE_W'(c);
    end
  end
  assign win_key = base_reg + KEY_WIDTH'(win_idx);

  // State register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_reg <= S_CLEAR;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (key_from_switches_changed) begin
      state_next = S_CLEAR;
    end else begin
      case (state_reg)
        S_IDLE:     if (ROM_mem_read) state_next = S_LOAD;
        S_CLEAR:    state_next = S_IDLE;
        S_LOAD:     state_next = S_INIT;
        S_INIT:     if (phase_complete) state_next = S_SHUFFLE;
                    else if (wd_expired) state_next = S_TIMEOUT;
        S_SHUFFLE:  if (phase_complete) state_next = S_READ_S;
                    else if (wd_expired) state_next = S_TIMEOUT;
        S_READ_S:   if (phase_complete) state_next = S_DECRYPT;
                    else if (wd_expired) state_next = S_TIMEOUT;
        S_DECRYPT:  if (phase_complete) state_next = S_CHECK;
                    else if (wd_expired) state_next = S_TIMEOUT;
        S_CHECK:    if (|valid_seen_reg) state_next = S_FOUND;
                    else if (!mode_reg || last_batch) state_next = S_FAIL;
                    else state_next = S_NEXT_KEY;
        S_NEXT_KEY: state_next = S_INIT;
        S_FOUND:    state_next = S_FOUND;
        S_FAIL:     state_next = S_FAIL;
        S_TIMEOUT:  state_next = S_TIMEOUT;
        default:    state_next = S_CLEAR;
      endcase
    end
  end

  // Datapath: batch base, enables, completion masks, watchdog, result.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      base_reg       <= '0;
      core_en_reg    <= '0;
      seen_reg       <= '0;
      valid_seen_reg <= '0;
      mode_reg       <= 1'b0;
      entry_reg      <= 1'b0;
      watchdog_reg   <= '0;
      found_key_reg  <= '0;
      found_core_reg <= '0;
    end else begin
      entry_reg <= state_change;

      // Masks are zero on entry; the entry cycle's done inputs may be stale
      // from the previous phase and are not accumulated.
      if (state_change || !in_phase) seen_reg <= '0;
      else if (!entry_reg)           seen_reg <= seen_reg | (phase_done_in & core_en_reg);

      if ((state_change && state_next == S_DECRYPT) || state_reg == S_CLEAR)
        valid_seen_reg <= '0;
      else if (state_reg == S_DECRYPT && !entry_reg)
        valid_seen_reg <= valid_seen_reg | (decrypt_valid & decrypt_done & core_en_reg);

      if (state_change || !in_phase) watchdog_reg <= '0;
      else                           watchdog_reg <= watchdog_reg + 32'd1;

      case (state_reg)
        S_CLEAR: begin
          base_reg       <= '0;
          core_en_reg    <= '0;
          mode_reg       <= 1'b0;
          found_key_reg  <= '0;
          found_core_reg <= '0;
        end
        S_LOAD: begin
          base_reg    <= load_base_ext[KEY_WIDTH-1:0];
          core_en_reg <= load_en;
          mode_reg    <= search_mode;
        end
        S_NEXT_KEY: begin
          base_reg    <= next_base_ext[KEY_WIDTH-1:0];
          core_en_reg <= next_en;
        end
        S_CHECK: begin
          if (|valid_seen_reg) begin
            found_key_reg  <= win_key;
            found_core_reg <= win_idx;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-core key registers, loaded alongside the batch base so they read
  // zero out of reset rather than base+c.
  genvar gi;
  generate
    for (gi = 0; gi < N_CORES; gi++) begin : g_core
      logic [KEY_WIDTH-1:0] key_reg;
      always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)                        key_reg <= '0;
        else if (state_reg == S_CLEAR)    key_reg <= '0;
        else if (state_reg == S_LOAD)     key_reg <= load_base_ext[KEY_WIDTH-1:0] + KEY_WIDTH'(gi);
        else if (state_reg == S_NEXT_KEY) key_reg <= next_base_ext[KEY_WIDTH-1:0] + KEY_WIDTH'(gi);
      end
      assign core_key[gi*KEY_WIDTH +: KEY_WIDTH] = key_reg;
    end
  endgenerate

  // Output decode
  always_comb begin
    reset_all     = (state_reg == S_CLEAR);
    start_init    = (state_reg == S_INIT);
    start_shuffle = (state_reg == S_SHUFFLE);
    start_read    = (state_reg == S_READ_S);
    start_decrypt = (state_reg == S_DECRYPT);
    found         = (state_reg == S_FOUND);
    exhausted     = (state_reg == S_FAIL);
    timeout_err   = (state_reg == S_TIMEOUT);
    done          = (state_reg == S_FOUND) || (state_reg == S_FAIL) || (state_reg == S_TIMEOUT);
    current_state = state_reg;
    core_en       = core_en_reg;
    found_key     = found_key_reg;
    found_core    = found_core_reg;
  end

endmodule

// File: tb/tb_key_search_sequencer.sv
// Bench for key_search_sequencer (N_CORES=4, KEY_MIN=0, KEY_MAX=9,
// TIMEOUT_CYCLES=16). A core responder answers every phase with per-core
// done pulses at random delays plus a stale pulse in the entry cycle. A
// table of hand-computed cases and random cases checked against a
// batch-level model cover the search. Hand sequences cover timeout,
// restart mid-DECRYPT, and reset mid-SHUFFLE.
module tb_key_search_sequencer;

  localparam int KMIN = 0;
  localparam int KMAX = 9;

  logic        CLOCK_50;
  logic        reset;
  logic        key_from_switches_changed;
  logic        search_mode;
  logic [23:0] switch_key;
  logic        ROM_mem_read;
  logic [3:0]  init_done, shuffle_done, read_done, decrypt_done, decrypt_valid;
  logic        reset_all, start_init, start_shuffle, start_read, start_decrypt;
  logic [95:0] core_key;
  logic [3:0]  core_en;
  logic [3:0]  current_state;
  logic        found, exhausted, timeout_err, done;
  logic [23:0] found_key;
  logic [1:0]  found_core;

  key_search_sequencer #(
    .N_CORES(4), .KEY_WIDTH(24), .KEY_MIN(24'd0), .KEY_MAX(24'd9), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .key_from_switches_changed(key_from_switches_changed),
    .search_mode(search_mode), .switch_key(switch_key), .ROM_mem_read(ROM_mem_read),
    .init_done(init_done), .shuffle_done(shuffle_done), .read_done(read_done),
    .decrypt_done(decrypt_done), .decrypt_valid(decrypt_valid),
    .reset_all(reset_all), .start_init(start_init), .start_shuffle(start_shuffle),
    .start_read(start_read), .start_decrypt(start_decrypt),
    .core_key(core_key), .core_en(core_en), .current_state(current_state),
    .found(found), .exhausted(exhausted), .timeout_err(timeout_err), .done(done),
    .found_key(found_key), .found_core(found_core)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  int tests_run    = 0;
  int tests_failed = 0;

  // Shared with the core responder
  bit          cur_mode = 1'b0;
  logic [11:0] cur_vps  = '0;
  bit          stall_core3_shuffle = 1'b0;
  int          r_prev  = -1;
  int          r_cyc   = 0;
  int          r_batch = -1;
  int          r_exp   = 0;
  int          r_delay [4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  // ---------------- reference model (batch level) ----------------
  function automatic logic [3:0] en_model(input bit mode, input int b);
    logic [3:0] e;
    e = '0;
    for (int c = 0; c < 4; c++)
      e[c] = mode ? (KMIN + 4*b + c <= KMAX) : (c == 0);
    return e;
  endfunction

  function automatic logic [23:0] key_model(input bit mode, input logic [23:0] key,
                                            input int b, input int c);
    int unsigned s;
    s = mode ? 32'(KMIN + 4*b + c) : (32'(key) + 32'(c));
    return s[23:0];
  endfunction

  function automatic void model_outcome(input bit mode, input logic [23:0] key,
                                        input logic [11:0] vps, output int st,
                                        output logic [23:0] fk, output int fc, output int nk);
    logic [3:0] hit;
    st = 10; fk = '0; fc = 0; nk = 0;
    for (int b = 0; b < 3; b++) begin
      hit = vps[b*4 +: 4] & en_model(mode, b);
      if (hit != 4'h0) begin
        for (int c = 3; c >= 0; c--) if (hit[c]) fc = c;
        fk = key_model(mode, key, b, fc);
        st = 9;
        return;
      end
      if (!mode || (KMIN + 4*(b+1) > KMAX)) return;
      nk++;
    end
  endfunction

  // ---------------- core responder ----------------
  initial begin : responder
    int st;
    logic [3:0] en, vp;
    logic pulse;
    init_done = '0; shuffle_done = '0; read_done = '0; decrypt_done = '0; decrypt_valid = '0;
    forever begin
      @(negedge CLOCK_50);
      st = int'(current_state);
      if (st != r_prev) begin
        if (r_prev >= 3 && r_prev <= 6 && st == r_prev + 1)
          check("phase_len", 32'(r_cyc + 1), 32'(r_exp));
        r_cyc = 0;
        if (st == 2) r_batch = -1;
        if (st == 3) r_batch++;
        if (st >= 3 && st <= 6) begin
          en = en_model(cur_mode, r_batch);
          r_exp = 0;
          for (int c = 0; c < 4; c++) begin
            r_delay[c] = int'($urandom_range(1, 6));
            if (en[c] && r_delay[c] + 2 > r_exp) r_exp = r_delay[c] + 2;
          end
        end
      end else begin
        r_cyc++;
      end
      r_prev = st;
      init_done = '0; shuffle_done = '0; read_done = '0; decrypt_done = '0; decrypt_valid = '0;
      if (st >= 3 && st <= 6) begin
        vp = (r_batch >= 0 && r_batch < 3) ? cur_vps[r_batch*4 +: 4] : 4'h0;
        for (int c = 0; c < 4; c++) begin
          pulse = (r_cyc == 0) || (r_cyc == r_delay[c]);
          if (stall_core3_shuffle && st == 4 && c == 3) pulse = 1'b0;
          case (st)
            3: init_done[c]    = pulse;
            4: shuffle_done[c] = pulse;
            5: read_done[c]    = pulse;
            default: begin
              decrypt_done[c]  = pulse;
              // entry cycle: stale valid; otherwise valid only counts with done
              if (r_cyc == 0)  decrypt_valid[c] = 1'b1;
              else if (pulse)  decrypt_valid[c] = vp[c];
              else             decrypt_valid[c] = 1'($urandom_range(0, 1));
            end
          endcase
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic restart();
    ROM_mem_read = 1'b0;
    key_from_switches_changed = 1'b1;
    @(negedge CLOCK_50);
    key_from_switches_changed = 1'b0;
    @(negedge CLOCK_50);
  endtask

  task automatic wait_state(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLOCK_50);
      if (int'(current_state) == target) begin ok = 1'b1; break; end
    end
    check("wait_state_reached", 32'(ok), 32'd1);
  endtask

  task automatic run_case(input int idx, input bit mode, input logic [23:0] key,
                          input logic [11:0] vps, input int exp_st,
                          input logic [23:0] exp_fk, input int exp_fc, input int exp_nk);
    int st, prev, bidx, nk;
    bit ok;
    restart();
    cur_mode = mode; cur_vps = vps;
    search_mode = mode; switch_key = key; ROM_mem_read = 1'b1;
    prev = 0; bidx = -1; nk = 0; ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge CLOCK_50);
      st = int'(current_state);
      if (st == 3 && prev != 3) begin
        bidx++;
        check("core_en", 32'(core_en), 32'(en_model(mode, bidx)));
        for (int c = 0; c < 4; c++)
          check("core_key", 32'(core_key[c*24 +: 24]), 32'(key_model(mode, key, bidx, c)));
      end
      if (st == 8) nk++;
      prev = st;
      if (st >= 9 && st <= 11) begin ok = 1'b1; break; end
    end
    ROM_mem_read = 1'b0;
    check("terminal_reached", 32'(ok), 32'd1);
    check("final_state", 32'(current_state), 32'(exp_st));
    check("found", 32'(found), 32'(exp_st == 9));
    check("exhausted", 32'(exhausted), 32'(exp_st == 10));
    check("timeout_err", 32'(timeout_err), 32'd0);
    check("done", 32'(done), 32'd1);
    check("found_key", 32'(found_key), 32'(exp_fk));
    check("found_core", 32'(found_core), 32'(exp_fc));
    check("next_key_visits", 32'(nk), 32'(exp_nk));
    $display("[TB] case %0d mode=%0d key=0x%06h vps=0x%03h -> state=%0d found_key=0x%06h core=%0d next_key_visits=%0d",
             idx, mode, key, vps, current_state, found_key, found_core, nk);
    repeat (3) @(negedge CLOCK_50);
    check("absorbing_state", 32'(current_state), 32'(exp_st));
    check("found_key_hold", 32'(found_key), 32'(exp_fk));
  endtask

  typedef struct {
    bit          mode;
    logic [23:0] key;
    logic [11:0] vps;
    int          exp_st;
    logic [23:0] exp_fk;
    int          exp_fc;
    int          exp_nk;
  } vec_t;

  vec_t vecs [10];

  initial begin : main
    bit ok;
    int sh_cyc, st, m_st, m_fc, m_nk;
    logic [23:0] m_fk, rkey;
    logic [11:0] rvps;
    bit rmode;

    reset = 1'b1;
    key_from_switches_changed = 1'b0;
    search_mode = 1'b0; switch_key = '0; ROM_mem_read = 1'b0;

    // batch b valid pattern lives in vps[b*4 +: 4]
    vecs[0] = '{1'b0, 24'h000249, 12'h001, 9,  24'h000249, 0, 0};
    vecs[1] = '{1'b1, 24'h000000, 12'h400, 10, 24'h000000, 0, 2};
    vecs[2] = '{1'b1, 24'h000000, 12'h020, 9,  24'h000005, 1, 1};
    vecs[3] = '{1'b0, 24'h123456, 12'h000, 10, 24'h000000, 0, 0};
    vecs[4] = '{1'b0, 24'h123456, 12'h00E, 10, 24'h000000, 0, 0};
    vecs[5] = '{1'b1, 24'h000000, 12'h00A, 9,  24'h000001, 1, 0};
    vecs[6] = '{1'b1, 24'h000000, 12'h0C0, 9,  24'h000006, 2, 1};
    vecs[7] = '{1'b0, 24'hFFFFFF, 12'h001, 9,  24'hFFFFFF, 0, 0};
    vecs[8] = '{1'b1, 24'h000000, 12'h300, 9,  24'h000008, 0, 2};
    vecs[9] = '{1'b1, 24'h000000, 12'h200, 9,  24'h000009, 1, 2};

    // reset state
    repeat (2) @(negedge CLOCK_50);
    check("rst_state", 32'(current_state), 32'd1);
    check("rst_reset_all", 32'(reset_all), 32'd1);
    check("rst_starts", 32'({start_init, start_shuffle, start_read, start_decrypt}), 32'd0);
    check("rst_flags", 32'({found, exhausted, timeout_err, done}), 32'd0);
    check("rst_core_en", 32'(core_en), 32'd0);
    check("rst_core_key_lo", core_key[31:0], 32'd0);
    check("rst_found_key", 32'(found_key), 32'd0);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("idle_after_reset", 32'(current_state), 32'd0);
    check("idle_reset_all", 32'(reset_all), 32'd0);

    // table-driven cases
    for (int i = 0; i < 10; i++)
      run_case(i, vecs[i].mode, vecs[i].key, vecs[i].vps, vecs[i].exp_st,
               vecs[i].exp_fk, vecs[i].exp_fc, vecs[i].exp_nk);

    // random cases against the model
    for (int i = 10; i < 30; i++) begin
      rmode = 1'($urandom_range(0, 1));
      rkey  = (i % 4 == 0) ? 24'hFFFFFD + 24'(i % 3) : 24'($urandom);
      rvps  = '0;
      for (int j = 0; j < 12; j++) rvps[j] = ($urandom_range(0, 4) == 0);
      model_outcome(rmode, rkey, rvps, m_st, m_fk, m_fc, m_nk);
      run_case(i, rmode, rkey, rvps, m_st, m_fk, m_fc, m_nk);
    end

    // watchdog: core3 never completes SHUFFLE
    restart();
    cur_mode = 1'b1; cur_vps = '0; stall_core3_shuffle = 1'b1;
    search_mode = 1'b1; ROM_mem_read = 1'b1;
    sh_cyc = 0; ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge CLOCK_50);
      st = int'(current_state);
      if (st == 4) sh_cyc++;
      if (st >= 9 && st <= 11) begin ok = 1'b1; break; end
    end
    ROM_mem_read = 1'b0;
    check("to_terminal", 32'(ok), 32'd1);
    check("to_state", 32'(current_state), 32'd11);
    check("to_shuffle_cycles", 32'(sh_cyc), 32'd16);
    check("to_flags", 32'({found, exhausted, timeout_err, done}), 32'b0011);
    $display("[TB] timeout case: state=%0d shuffle_cycles=%0d", current_state, sh_cyc);
    stall_core3_shuffle = 1'b0;

    // restart request during DECRYPT
    restart();
    cur_mode = 1'b1; cur_vps = '0;
    search_mode = 1'b1; ROM_mem_read = 1'b1;
    wait_state(6, ok);
    key_from_switches_changed = 1'b1;
    ROM_mem_read = 1'b0;
    @(negedge CLOCK_50);
    check("kc_state", 32'(current_state), 32'd1);
    check("kc_reset_all", 32'(reset_all), 32'd1);
    check("kc_flags", 32'({found, exhausted, timeout_err, done}), 32'd0);
    check("kc_start_decrypt", 32'(start_decrypt), 32'd0);
    key_from_switches_changed = 1'b0;
    @(negedge CLOCK_50);
    check("kc_idle", 32'(current_state), 32'd0);
    $display("[TB] restart-in-decrypt case: state=%0d", current_state);

    // asynchronous reset mid-SHUFFLE
    restart();
    cur_mode = 1'b0; cur_vps = '0;
    search_mode = 1'b0; switch_key = 24'h00ABCD; ROM_mem_read = 1'b1;
    wait_state(4, ok);
    reset = 1'b1;
    ROM_mem_read = 1'b0;
    #1;
    check("ar_state", 32'(current_state), 32'd1);
    check("ar_reset_all", 32'(reset_all), 32'd1);
    check("ar_start_shuffle", 32'(start_shuffle), 32'd0);
    check("ar_flags", 32'({found, exhausted, timeout_err, done}), 32'd0);
    check("ar_core_en", 32'(core_en), 32'd0);
    check("ar_core_key0", 32'(core_key[23:0]), 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("ar_idle", 32'(current_state), 32'd0);
    $display("[TB] reset-in-shuffle case: state=%0d", current_state);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin : time_guard
    #2_000_000;
    $display("FAIL time_guard: got simulation still running, want completion");
    $fatal(1, "time limit");
  end

endmodule
